clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen_pkg.sv | 10 +
 rtl/clk_en_gen_if.sv | 23 ++
 rtl/clk_en_channel.sv | 63 ++++++
 rtl/clk_en_gen.sv | 83 ++++++++
 tb/tb_clk_en_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared constants and types for the clk_en_gen phase-accumulator clock-enable generator.
package clk_en_gen_pkg;

  localparam int          ACC_WIDTH_DEF   = 32;
  localparam logic [31:0] DEFAULT_INC_DEF = 32'd102493553;
  localparam int          LOCK_CYCLES_DEF = 1024;

  typedef logic [3:0] chan_idx_t;

endpackage

// File: rtl/clk_en_gen_if.sv
// Control/status bundle of clk_en_gen; sync_req exists only when CLK_EN_GEN_PHASE_SYNC_EN is defined.
interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF
);
  logic                    wr_en;
  chan_idx_t               wr_chan;
  logic [ACC_WIDTH-1:0]    wr_inc;
  logic [NUM_CHANNELS-1:0] ch_en;
  logic                    ready;
  logic [NUM_CHANNELS-1:0] tick;
`ifdef CLK_EN_GEN_PHASE_SYNC_EN
  logic                    sync_req;

  modport master (output wr_en, wr_chan, wr_inc, ch_en, sync_req, input ready, tick);
  modport slave  (input wr_en, wr_chan, wr_inc, ch_en, sync_req, output ready, tick);
`else
  modport master (output wr_en, wr_chan, wr_inc, ch_en, input ready, tick);
  modport slave  (input wr_en, wr_chan, wr_inc, ch_en, output ready, tick);
`endif
endinterface

// File: rtl/clk_en_channel.sv
// One clock-enable channel: increment register, phase accumulator and registered carry tick.
module clk_en_channel
  import clk_en_gen_pkg::*;
#(
  parameter int          ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter logic [31:0] DEFAULT_INC = DEFAULT_INC_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 wr_i,
  input  logic [ACC_WIDTH-1:0] wr_inc_i,
  input  logic                 run_i,
  input  logic                 clr_i,
  output logic                 tick_o
);
  localparam logic [ACC_WIDTH-1:0] INC_RST  = DEFAULT_INC[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

  logic [ACC_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, sum_s;
  logic                 carry_s, tick_q, tick_d;

  // Next accumulator/tick; a clear wins over running so no wrap tick escapes it.
  always_comb begin
    {carry_s, sum_s} = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d            = acc_q;
    tick_d           = 1'b0;
    if (clr_i) begin
      acc_d  = ACC_ZERO;
      tick_d = 1'b0;
    end else if (run_i) begin
      acc_d  = sum_s;
      tick_d = carry_s;
    end else begin
      acc_d  = acc_q;
      tick_d = 1'b0;
    end
  end

  // Increment loads independently of the clear.
  always_comb begin
    if (wr_i) begin
      inc_d = wr_inc_i;
    end else begin
      inc_d = inc_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= ACC_ZERO;
      inc_q  <= INC_RST;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified multi-channel clock-enable generator; CLK_EN_GEN_PHASE_SYNC_EN adds a sync_req phase clear.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter logic [31:0] DEFAULT_INC  = DEFAULT_INC_DEF,
  parameter int          LOCK_CYCLES  = LOCK_CYCLES_DEF
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         pll_locked,
  clk_en_gen_if.slave  bus
);
  localparam int              CNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                    sync1_q, sync2_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    active_s, clr_s, sync_s, wr_ok_s;
  logic [NUM_CHANNELS-1:0] tick_s;

  // Lock qualification: count consecutive synchronised-high cycles, saturating at LOCK_CYCLES.
  always_comb begin
    if (!sync2_q) begin
      cnt_d   = {CNT_W{1'b0}};
      ready_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = cnt_q;
      ready_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_ONE;
      ready_d = ((cnt_q + CNT_ONE) == CNT_MAX);
    end
  end

  // Synchroniser and lock-filter registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

`ifdef CLK_EN_GEN_PHASE_SYNC_EN
  assign sync_s = bus.sync_req;
`else
  assign sync_s = 1'b0;
`endif

  // Lock loss clears accumulators on the same edge that ready drops.
  assign active_s = ready_q & sync2_q;
  assign clr_s    = ~active_s | sync_s;
  assign wr_ok_s  = bus.wr_en && ({1'b0, bus.wr_chan} < 5'(NUM_CHANNELS));

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    clk_en_channel #(
      .ACC_WIDTH   (ACC_WIDTH),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .wr_i     (wr_ok_s && (bus.wr_chan == chan_idx_t'(i))),
      .wr_inc_i (bus.wr_inc),
      .run_i    (active_s && bus.ch_en[i]),
      .clr_i    (clr_s),
      .tick_o   (tick_s[i])
    );
  end

  assign bus.ready = ready_q;
  assign bus.tick  = tick_s;

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen (ACC_WIDTH=8, LOCK_CYCLES=4, NUM_CHANNELS=4, DEFAULT_INC=128).
module tb_clk_en_gen;
  import clk_en_gen_pkg::*;

  typedef struct {
    logic       rdy;
    logic [3:0] tk;
    string      tag;
  } exp_t;

  logic  sys_clk;
  logic  rst_n;
  logic  pll_locked;
  exp_t  exp_q[$];
  string cur_tag;
  int    errors;
  int    checks;

  clk_en_gen_if #(.NUM_CHANNELS(4), .ACC_WIDTH(8)) bus ();

  clk_en_gen #(
    .NUM_CHANNELS (4),
    .ACC_WIDTH    (8),
    .DEFAULT_INC  (32'd128),
    .LOCK_CYCLES  (4)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .bus        (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Queue the outputs expected right after the next rising edge, then let it happen.
  task automatic step(input logic er, input logic [3:0] et);
    exp_t e;
    e.rdy = er;
    e.tk  = et;
    e.tag = cur_tag;
    exp_q.push_back(e);
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wr(input logic en, input logic [3:0] chan, input logic [7:0] inc);
    bus.wr_en   = en;
    bus.wr_chan = chan;
    bus.wr_inc  = inc;
  endtask

  // Monitor: one DUT output sample per cycle, compared against the oldest expectation.
  always @(posedge sys_clk) begin
    exp_t m;
    #1;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      checks = checks + 1;
      if (bus.ready !== m.rdy || bus.tick !== m.tk) begin
        errors = errors + 1;
        $display("FAIL %s @%0t: ready=%b tick=%b, expected ready=%b tick=%b",
                 m.tag, $time, bus.ready, bus.tick, m.rdy, m.tk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    bus.ch_en   = 4'b0000;
    wr(1'b0, 4'd0, 8'd0);
`ifdef CLK_EN_GEN_PHASE_SYNC_EN
    bus.sync_req = 1'b0;
`endif
    @(posedge sys_clk);
    #2;

    cur_tag = "reset";
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    rst_n = 1'b1;

    // Lock qualifies after 2 sync + 4 count edges; default inc 128 ticks every 2nd addition.
    cur_tag    = "lock_ready";
    pll_locked = 1'b1;
    bus.ch_en  = 4'b1111;
    for (int k = 1; k <= 5; k++) step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    cur_tag = "default_inc";
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);

    cur_tag   = "inc64";
    bus.ch_en = 4'b0000;
    wr(1'b1, 4'd0, 8'd64);
    step(1'b1, 4'b0000);
    wr(1'b0, 4'd0, 8'd0);
    bus.ch_en = 4'b0001;
    for (int k = 1; k <= 12; k++) step(1'b1, (k % 4 == 0) ? 4'b0001 : 4'b0000);

    cur_tag   = "inc255_inc0";
    bus.ch_en = 4'b0000;
    wr(1'b1, 4'd1, 8'd255);
    step(1'b1, 4'b0000);
    wr(1'b1, 4'd2, 8'd0);
    step(1'b1, 4'b0000);
    wr(1'b0, 4'd0, 8'd0);
    bus.ch_en = 4'b0110;
    step(1'b1, 4'b0000);
    for (int k = 1; k <= 5; k++) step(1'b1, 4'b0010);

    // Out-of-range write must not alias onto channel 3 (7 mod 4).
    cur_tag   = "bad_chan";
    bus.ch_en = 4'b0000;
    wr(1'b1, 4'd7, 8'd1);
    step(1'b1, 4'b0000);
    wr(1'b0, 4'd0, 8'd0);
    bus.ch_en = 4'b1011;
    step(1'b1, 4'b0010);
    step(1'b1, 4'b1010);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b1011);

    cur_tag   = "ch_en_toggle";
    bus.ch_en = 4'b0001;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    bus.ch_en = 4'b0000;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    bus.ch_en = 4'b0001;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    for (int k = 1; k <= 3; k++) step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);

    // One-cycle lock drop at acc=64; inc[0]=128 written on the clearing edge.
    cur_tag = "lock_drop";
    step(1'b1, 4'b0000);
    pll_locked = 1'b0;
    step(1'b1, 4'b0000);
    pll_locked = 1'b1;
    step(1'b1, 4'b0000);
    wr(1'b1, 4'd0, 8'd128);
    step(1'b0, 4'b0000);
    wr(1'b0, 4'd0, 8'd0);
    for (int k = 1; k <= 3; k++) step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    cur_tag = "relock_resume";
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);

`ifdef CLK_EN_GEN_PHASE_SYNC_EN
    cur_tag   = "sync_req";
    bus.ch_en = 4'b0000;
    wr(1'b1, 4'd0, 8'd64);
    step(1'b1, 4'b0000);
    wr(1'b1, 4'd1, 8'd64);
    step(1'b1, 4'b0000);
    wr(1'b0, 4'd0, 8'd0);
    bus.ch_en = 4'b0011;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    bus.sync_req = 1'b1;
    step(1'b1, 4'b0000);
    bus.sync_req = 1'b0;
    for (int k = 1; k <= 3; k++) step(1'b1, 4'b0000);
    step(1'b1, 4'b0011);
`endif

    // Reset mid-run restores default increments and restarts lock qualification.
    cur_tag   = "reset_mid";
    bus.ch_en = 4'b1111;
    rst_n     = 1'b0;
    step(1'b0, 4'b0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
